// File: rtl/exe_mem_stage_pkg.sv
// Shared encodings and widths for the EXE/MEM pipeline boundary.
package exe_mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 4;
  localparam int FLAG_W = 4;

  // Flag bit positions inside every 4-bit {N,Z,C,V} vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    EXE_MOV = 4'b0001,
    EXE_MVN = 4'b1001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000
  } exe_cmd_e;

  typedef struct packed {
    logic valid;
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
  } ctrl_t;

endpackage

// File: rtl/exe_mem_stage_status_register.sv
// Architectural {N,Z,C,V} register with a free-running count of writes.
import exe_mem_stage_pkg::*;

module status_register (
  input  logic              clk,
  input  logic              rst,
  input  logic              update_en,
  input  logic [FLAG_W-1:0] sr_in,
  output logic [FLAG_W-1:0] status,
  output logic [15:0]       flag_updates
);

  // Counter wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status       <= '0;
      flag_updates <= '0;
    end else if (update_en) begin
      status       <= sr_in;
      flag_updates <= flag_updates + 16'd1;
    end
  end

endmodule

// File: rtl/exe_mem_stage.sv
// EXE->MEM pipeline register with flush/freeze control and the flag register.
import exe_mem_stage_pkg::*;

module exe_mem_stage (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              s_in,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [REG_W-1:0]  dest_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [FLAG_W-1:0] sr_in,
  input  logic [DATA_W-1:0] val_rm_in,
  output logic              valid_out,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic [REG_W-1:0]  dest_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic [FLAG_W-1:0] status,
  output logic              c_out,
  output logic [15:0]       flag_updates
);

  ctrl_t ctrl_q;
  logic  update_en;

  // Flush beats freeze: a bubble clears control but leaves data untouched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q         <= '0;
      dest_out       <= '0;
      alu_result_out <= '0;
      val_rm_out     <= '0;
    end else if (flush) begin
      ctrl_q <= '0;
    end else if (!freeze) begin
      ctrl_q         <= '{valid: valid_in, wb_en: wb_en_in,
                          mem_r_en: mem_r_en_in, mem_w_en: mem_w_en_in};
      dest_out       <= dest_in;
      alu_result_out <= alu_result_in;
      val_rm_out     <= val_rm_in;
    end
  end

  assign valid_out    = ctrl_q.valid;
  assign wb_en_out    = ctrl_q.wb_en;
  assign mem_r_en_out = ctrl_q.mem_r_en;
  assign mem_w_en_out = ctrl_q.mem_w_en;

  assign update_en = valid_in & s_in & ~freeze & ~flush;

  status_register u_status (
    .clk          (clk),
    .rst          (rst),
    .update_en    (update_en),
    .sr_in        (sr_in),
    .status       (status),
    .flag_updates (flag_updates)
  );

  // Carry comes from the committed register only; sr_in is never bypassed
  assign c_out = status[FLAG_C];

endmodule

// File: tb/tb_exe_mem_stage.sv
// Randomized + directed check of exe_mem_stage against a behavioural model.
module tb_exe_mem_stage;

  logic        clk = 0, rst = 1;
  logic        freeze = 0, flush = 0, valid_in = 0, s_in = 0;
  logic        wb_en_in = 0, mem_r_en_in = 0, mem_w_en_in = 0;
  logic [3:0]  dest_in = 0, sr_in = 0;
  logic [31:0] alu_result_in = 0, val_rm_in = 0;
  logic        valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, c_out;
  logic [3:0]  dest_out, status;
  logic [31:0] alu_result_out, val_rm_out;
  logic [15:0] flag_updates;

  int checks = 0, errors = 0;

  // expected architectural state
  logic        e_valid, e_wb, e_mr, e_mw;
  logic [3:0]  e_dest, e_status;
  logic [31:0] e_alu, e_rm;
  int          e_cnt;

  exe_mem_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .s_in(s_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .dest_in(dest_in), .alu_result_in(alu_result_in),
    .sr_in(sr_in), .val_rm_in(val_rm_in), .valid_out(valid_out),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .dest_out(dest_out),
    .alu_result_out(alu_result_out), .val_rm_out(val_rm_out), .status(status),
    .c_out(c_out), .flag_updates(flag_updates)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    {e_valid, e_wb, e_mr, e_mw} = '0;
    e_dest = 0; e_alu = 0; e_rm = 0; e_status = 0; e_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, e_valid});
    chk({tag, ".wb"},    {31'd0, wb_en_out}, {31'd0, e_wb});
    chk({tag, ".mr"},    {31'd0, mem_r_en_out}, {31'd0, e_mr});
    chk({tag, ".mw"},    {31'd0, mem_w_en_out}, {31'd0, e_mw});
    chk({tag, ".dest"},  {28'd0, dest_out}, {28'd0, e_dest});
    chk({tag, ".alu"},   alu_result_out, e_alu);
    chk({tag, ".rm"},    val_rm_out, e_rm);
    chk({tag, ".status"}, {28'd0, status}, {28'd0, e_status});
    chk({tag, ".c_out"}, {31'd0, c_out}, {31'd0, e_status[1]});
    chk({tag, ".cnt"},   {16'd0, flag_updates}, e_cnt);
  endtask

  // Advance one edge: update the model from the presented inputs, then compare.
  task automatic tick(input string tag, input bit do_chk);
    if (flush) begin
      {e_valid, e_wb, e_mr, e_mw} = '0;
    end else if (!freeze) begin
      {e_valid, e_wb, e_mr, e_mw} = {valid_in, wb_en_in, mem_r_en_in, mem_w_en_in};
      e_dest = dest_in; e_alu = alu_result_in; e_rm = val_rm_in;
    end
    if (valid_in && s_in && !freeze && !flush) begin
      e_status = sr_in;
      e_cnt    = (e_cnt + 1) % 65536;
    end
    @(posedge clk); #1;
    if (do_chk) check_all(tag);
  endtask

  task automatic rand_data();
    valid_in = 1'($urandom); s_in = 1'($urandom);
    wb_en_in = 1'($urandom); mem_r_en_in = 1'($urandom); mem_w_en_in = 1'($urandom);
    dest_in = 4'($urandom); sr_in = 4'($urandom);
    alu_result_in = $urandom; val_rm_in = $urandom;
  endtask

  initial begin
    model_reset();
    rand_data();
    #1 rst = 0;           // async reset before any clock edge
    #1 check_all("reset");
    @(negedge clk); rst = 1;
    #1;

    // pass-through, no flag write
    valid_in = 1; s_in = 0; wb_en_in = 1; mem_r_en_in = 0; mem_w_en_in = 0;
    dest_in = 4'd5; alu_result_in = 32'd13 + 32'd15; sr_in = 4'b1111;
    tick("pass", 1);
    chk("pass.alu28", alu_result_out, 32'd28);
    chk("pass.dest5", {28'd0, dest_out}, 32'd5);

    // flag write and carry feedback
    s_in = 1; sr_in = 4'b0010;
    tick("flag", 1);
    chk("flag.c_out", {31'd0, c_out}, 32'd1);
    chk("flag.cnt1", {16'd0, flag_updates}, 32'd1);
    s_in = 0; sr_in = 4'b1100;
    tick("flag_hold", 1);
    chk("flag_hold.status", {28'd0, status}, 32'b0010);

    // flush wins over freeze
    freeze = 1; flush = 1; valid_in = 1; s_in = 1; sr_in = 4'b0100;
    tick("flush_freeze", 1);
    chk("flush_freeze.valid", {31'd0, valid_out}, 32'd0);
    freeze = 0; flush = 0;

    // freeze hold
    s_in = 0; alu_result_in = 32'hEE6B2800;
    tick("load", 1);
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      tick("freeze", 1);
      chk("freeze.alu", alu_result_out, 32'hEE6B2800);
    end
    freeze = 0;
    rand_data();
    tick("release", 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_data();
      flush  = ($urandom_range(0, 4) == 0);
      freeze = ($urandom_range(0, 3) == 0);
      tick("rand", 1);
    end
    flush = 0; freeze = 0;

    // drive the counter up to FFFF, then wrap
    valid_in = 1; s_in = 1;
    for (int i = 0; i < 70000 && e_cnt != 16'hFFFF; i++) begin
      sr_in = 4'($urandom);
      tick("fill", 0);
    end
    check_all("ffff");
    chk("ffff.cnt", {16'd0, flag_updates}, 32'h0000FFFF);
    sr_in = 4'b1010;
    tick("wrap", 1);
    chk("wrap.cnt", {16'd0, flag_updates}, 32'd0);

    // async reset mid-cycle
    rand_data();
    @(posedge clk); #2;
    rst = 0; model_reset();
    #1 check_all("midreset");
    freeze = 1; flush = 1;
    @(posedge clk); #1 check_all("reset_over_ctrl");
    @(negedge clk); rst = 1; freeze = 0; flush = 0;
    rand_data();
    tick("post_reset", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
